mandelbrot_vram_writer: RTL



---
 rtl/mandelbrot_vram_writer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mandelbrot_vram_writer.sv
// Mandelbrot result-stream consumer: optionally clears vram at frame start,
// then maps iteration counts to palette indices and writes them to vram.
// Optional feature macro: MANDELBROT_VRAM_WRITER_COLOR_CYCLE_EN adds color_ofs,
// a palette rotation applied to out-of-set pixels.
module mandelbrot_vram_writer #(
  parameter int IW           = 8,
  parameter int MAXITERS     = 256,
  parameter int AW           = 19,
  parameter int DW           = 8,
  parameter int NPIXELS      = 307200,
  parameter int CLR_ON_START = 1,
  parameter int CLR_COLOR    = 0,
  parameter int IN_COLOR     = 0
) (
  input  logic          clk,
  input  logic          clk_en,
  input  logic          rst,
  input  logic          en,
  output logic          busy,
  output logic          done,
  output logic          adr_err,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [IW-1:0] in_dat,
  input  logic [AW-1:0] in_adr,
`ifdef MANDELBROT_VRAM_WRITER_COLOR_CYCLE_EN
  input  logic [DW-1:0] color_ofs,
`endif
  output logic          vram_we,
  output logic [AW-1:0] vram_adr,
  output logic [DW-1:0] vram_dat
);

  // Counter must be able to hold NPIXELS itself after the frame completes.
  localparam int CW = $clog2(NPIXELS + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIXELS - 1);
  localparam logic [IW-1:0] INSET_N  = IW'(MAXITERS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adr_err_q, adr_err_d;
  logic          vram_we_q, vram_we_d;
  logic [AW-1:0] vram_adr_q, vram_adr_d;
  logic [DW-1:0] vram_dat_q, vram_dat_d;
  logic [DW-1:0] map_dat;
  logic          xfer;
  logic          adr_ok;

  assign xfer   = in_vld && (state_q == RUN) && clk_en;
  assign adr_ok = (32'(in_adr) < NPIXELS);

  // Iteration count to palette index; in-set pixels get a fixed color.
  always_comb begin
`ifdef MANDELBROT_VRAM_WRITER_COLOR_CYCLE_EN
    map_dat = DW'(in_dat) + color_ofs;
`else
    map_dat = DW'(in_dat);
`endif
    if (in_dat == INSET_N) begin
      map_dat = DW'(IN_COLOR);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the counter index doubles as the clear address.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = (CLR_ON_START != 0) ? CLEAR : RUN;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_PIX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer && (cnt_q == LAST_PIX)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded purely from state so in_rdy never depends on in_vld.
  always_comb begin
    in_rdy = (state_q == RUN);
    busy   = (state_q == CLEAR) || (state_q == RUN);
    done   = (state_q == DONE);
  end

  // Datapath next values: clear sweep, registered result writes, pixel count.
  always_comb begin
    cnt_d      = cnt_q;
    adr_err_d  = adr_err_q;
    vram_we_d  = 1'b0;
    vram_adr_d = vram_adr_q;
    vram_dat_d = vram_dat_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          cnt_d     = '0;
          adr_err_d = 1'b0;
          if (CLR_ON_START != 0) begin
            // Preload the first clear write so it lines up with the CLEAR state.
            vram_we_d  = 1'b1;
            vram_adr_d = '0;
            vram_dat_d = DW'(CLR_COLOR);
          end
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_PIX) begin
          cnt_d = '0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          vram_we_d  = 1'b1;
          vram_adr_d = AW'(cnt_q + 1'b1);
          vram_dat_d = DW'(CLR_COLOR);
        end
      end
      RUN: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (adr_ok) begin
            vram_we_d  = 1'b1;
            vram_adr_d = in_adr;
            vram_dat_d = map_dat;
          end else begin
            adr_err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, all qualified by clk_en so a held write is not repeated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      adr_err_q  <= 1'b0;
      vram_we_q  <= 1'b0;
      vram_adr_q <= '0;
      vram_dat_q <= '0;
    end else if (clk_en) begin
      cnt_q      <= cnt_d;
      adr_err_q  <= adr_err_d;
      vram_we_q  <= vram_we_d;
      vram_adr_q <= vram_adr_d;
      vram_dat_q <= vram_dat_d;
    end
  end

  assign adr_err  = adr_err_q;
  assign vram_we  = vram_we_q;
  assign vram_adr = vram_adr_q;
  assign vram_dat = vram_dat_q;

endmodule
